// File: rtl/types_pkg.sv
// Shared types and constants for the dispatch stage: rename payload, issue
// payload with operand ready bits, ROB allocation record and IQ selector.
package types_pkg;

  localparam int NUM_PREGS = 128;
  localparam int PREG_W    = 7;
  localparam int TAG_W     = 4;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [31:0]       pc;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
    logic [31:0]       imm;
    logic [TAG_W-1:0]  rob_tag;
    logic              fu_alu;
    logic              fu_br;
    logic              fu_mem;
    logic [3:0]        alu_op;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
  } rename_data;

  typedef struct packed {
    rename_data ren;
    logic       ps1_rdy;
    logic       ps2_rdy;
  } dispatch_data;

  typedef struct packed {
    logic [31:0]       pc;
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
    logic [TAG_W-1:0]  rob_tag;
    logic              is_branch;
    logic              is_store;
  } rob_alloc_data;

  typedef enum logic [1:0] {
    IQ_ALU = 2'd0,
    IQ_BR  = 2'd1,
    IQ_MEM = 2'd2
  } iq_sel_e;

  // Branch flag has priority over memory; anything else goes to the ALU queue.
  function automatic iq_sel_e route_of(input rename_data d);
    if (d.fu_br)       return IQ_BR;
    else if (d.fu_mem) return IQ_MEM;
    else               return IQ_ALU;
  endfunction

endpackage

// File: rtl/busy_table.sv
// Physical-register busy bits with one branch snapshot; read ports bypass a
// same-cycle CDB clear so a just-written-back source reads as ready.
module busy_table
  import types_pkg::*;
#(
  parameter int NUM_P = NUM_PREGS,
  parameter int PW    = PREG_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          set_en,
  input  logic [PW-1:0] set_preg,
  input  logic          clr_en,
  input  logic [PW-1:0] clr_preg,
  input  logic          checkpoint,
  input  logic          restore,
  input  logic [PW-1:0] rd_preg1,
  input  logic [PW-1:0] rd_preg2,
  output logic          rd_rdy1,
  output logic          rd_rdy2
);

  logic [NUM_P-1:0] busy;
  logic [NUM_P-1:0] snap;
  logic [NUM_P-1:0] set_mask;
  logic [NUM_P-1:0] clr_mask;
  logic [NUM_P-1:0] busy_n;
  logic [NUM_P-1:0] snap_n;

  // Set is applied after clear so a reallocated preg stays busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_preg] = 1'b1;
    if (clr_en) clr_mask[clr_preg] = 1'b1;

    if (restore) busy_n = snap & ~clr_mask;
    else         busy_n = (busy & ~clr_mask) | set_mask;
    busy_n[0] = 1'b0;

    if (checkpoint) snap_n = busy & ~clr_mask;
    else            snap_n = snap & ~clr_mask;
    snap_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
      snap <= '0;
    end else begin
      busy <= busy_n;
      snap <= snap_n;
    end
  end

  assign rd_rdy1 = (rd_preg1 == '0) || !busy[rd_preg1] || (clr_en && (clr_preg == rd_preg1));
  assign rd_rdy2 = (rd_preg2 == '0) || !busy[rd_preg2] || (clr_en && (clr_preg == rd_preg2));

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: accepts one renamed instruction per cycle, allocates its ROB
// entry, samples operand readiness and holds it in a one-deep issue register.
module dispatch
  import types_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  input  rename_data        data_in,
  output logic              ready_in,
  output logic              rob_alloc_valid,
  output rob_alloc_data     rob_alloc,
  input  logic              rob_ready,
  input  logic              cdb_valid,
  input  logic [PREG_W-1:0] cdb_preg,
  input  logic              mispredict,
  output logic              alu_valid,
  output logic              br_valid,
  output logic              mem_valid,
  input  logic              alu_ready,
  input  logic              br_ready,
  input  logic              mem_ready,
  output dispatch_data      iq_data
);

  logic         alu_vld_p1;
  logic         br_vld_p1;
  logic         mem_vld_p1;
  dispatch_data iq_data_p1;

  logic    occ;
  logic    fire;
  logic    accept;
  logic    is_branch;
  logic    ps1_rdy;
  logic    ps2_rdy;
  iq_sel_e sel;

  assign occ       = alu_vld_p1 | br_vld_p1 | mem_vld_p1;
  assign fire      = (alu_vld_p1 & alu_ready) | (br_vld_p1 & br_ready) | (mem_vld_p1 & mem_ready);
  assign ready_in  = reset_n && rob_ready && !mispredict && (!occ || fire);
  assign accept    = valid_in && ready_in;
  assign is_branch = (data_in.opcode == OPC_BRANCH);
  assign sel       = route_of(data_in);

  busy_table u_bt (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_en     (accept && (data_in.pd_new != '0)),
    .set_preg   (data_in.pd_new),
    .clr_en     (cdb_valid),
    .clr_preg   (cdb_preg),
    .checkpoint (accept && is_branch),
    .restore    (mispredict),
    .rd_preg1   (data_in.ps1),
    .rd_preg2   (data_in.ps2),
    .rd_rdy1    (ps1_rdy),
    .rd_rdy2    (ps2_rdy)
  );

  assign rob_alloc_valid     = accept;
  assign rob_alloc.pc        = data_in.pc;
  assign rob_alloc.pd_new    = data_in.pd_new;
  assign rob_alloc.pd_old    = data_in.pd_old;
  assign rob_alloc.rob_tag   = data_in.rob_tag;
  assign rob_alloc.is_branch = is_branch;
  assign rob_alloc.is_store  = (data_in.opcode == OPC_STORE);

  // Stage p1: issue register, held until the selected queue takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_vld_p1 <= 1'b0;
      br_vld_p1  <= 1'b0;
      mem_vld_p1 <= 1'b0;
      iq_data_p1 <= '0;
    end else if (mispredict) begin
      alu_vld_p1 <= 1'b0;
      br_vld_p1  <= 1'b0;
      mem_vld_p1 <= 1'b0;
    end else if (accept) begin
      alu_vld_p1 <= (sel == IQ_ALU);
      br_vld_p1  <= (sel == IQ_BR);
      mem_vld_p1 <= (sel == IQ_MEM);
      iq_data_p1 <= '{ren: data_in, ps1_rdy: ps1_rdy, ps2_rdy: ps2_rdy};
    end else if (fire) begin
      alu_vld_p1 <= 1'b0;
      br_vld_p1  <= 1'b0;
      mem_vld_p1 <= 1'b0;
    end
  end

  assign alu_valid = alu_vld_p1;
  assign br_valid  = br_vld_p1;
  assign mem_valid = mem_vld_p1;
  assign iq_data   = iq_data_p1;

endmodule

// File: tb/tb_dispatch.sv
// Scoreboard bench for dispatch: a busy-table array model predicts each
// accepted instruction's route and ready bits; a monitor checks the IQ port.
module tb_dispatch;
  import types_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              valid_in;
  rename_data        data_in;
  logic              ready_in;
  logic              rob_alloc_valid;
  rob_alloc_data     rob_alloc;
  logic              rob_ready;
  logic              cdb_valid;
  logic [PREG_W-1:0] cdb_preg;
  logic              mispredict;
  logic              alu_valid, br_valid, mem_valid;
  logic              alu_ready, br_ready, mem_ready;
  dispatch_data      iq_data;

  dispatch dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .rob_alloc_valid(rob_alloc_valid), .rob_alloc(rob_alloc),
    .rob_ready(rob_ready), .cdb_valid(cdb_valid), .cdb_preg(cdb_preg),
    .mispredict(mispredict), .alu_valid(alu_valid), .br_valid(br_valid),
    .mem_valid(mem_valid), .alu_ready(alu_ready), .br_ready(br_ready),
    .mem_ready(mem_ready), .iq_data(iq_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] vmask; dispatch_data d; } exp_t;
  exp_t sb[$];
  bit   busy_m[NUM_PREGS];
  bit   snap_m[NUM_PREGS];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endfunction

  // Valid mask order is {alu, br, mem}.
  function automatic logic [2:0] mask_for(input rename_data d);
    if (d.fu_br)  return 3'b010;
    if (d.fu_mem) return 3'b001;
    return 3'b100;
  endfunction

  function automatic bit ready_for(input logic [2:0] m);
    return (m[2] && alu_ready) || (m[1] && br_ready) || (m[0] && mem_ready);
  endfunction

  function automatic bit preg_ready(input logic [6:0] p);
    return (p == 0) || !busy_m[p] || (cdb_valid && cdb_preg == p);
  endfunction

  // kind: 0 alu, 1 branch, 2 store, 3 load, 4 no FU flag, 5 all flags on a branch
  function automatic rename_data mk(input int kind, input logic [6:0] s1, input logic [6:0] s2,
                                    input logic [6:0] pd);
    rename_data d = '0;
    d.pc = $urandom; d.imm = $urandom; d.rob_tag = 4'($urandom);
    d.alu_op = 4'($urandom); d.func3 = 3'($urandom); d.func7 = 7'($urandom);
    d.pd_old = 7'($urandom); d.ps1 = s1; d.ps2 = s2; d.pd_new = pd;
    case (kind)
      0: begin d.fu_alu = 1'b1; d.opcode = 7'b0110011; end
      1: begin d.fu_br = 1'b1; d.opcode = 7'b1100011; d.pd_new = 0; end
      2: begin d.fu_mem = 1'b1; d.opcode = 7'b0100011; d.pd_new = 0; end
      3: begin d.fu_mem = 1'b1; d.opcode = 7'b0000011; end
      4: begin d.opcode = 7'b0010011; end
      default: begin d.fu_alu = 1'b1; d.fu_br = 1'b1; d.fu_mem = 1'b1;
                     d.opcode = 7'b1100011; d.pd_new = 0; end
    endcase
    return d;
  endfunction

  // Called in the negedge timestep right after inputs are driven.
  task automatic step();
    bit occ, fire, exp_rdy, acc;
    exp_t e;
    rob_alloc_data ra;
    occ  = (sb.size() != 0);
    fire = 1'b0;
    if (occ) fire = ready_for(sb[0].vmask);
    exp_rdy = reset_n && rob_ready && !mispredict && (!occ || fire);
    acc     = exp_rdy && valid_in;
    #2;
    chk("ready_in", 128'(ready_in), 128'(exp_rdy));
    chk("rob_alloc_valid", 128'(rob_alloc_valid), 128'(acc));
    if (acc) begin
      ra.pc = data_in.pc; ra.pd_new = data_in.pd_new; ra.pd_old = data_in.pd_old;
      ra.rob_tag = data_in.rob_tag;
      ra.is_branch = (data_in.opcode == 7'b1100011);
      ra.is_store  = (data_in.opcode == 7'b0100011);
      chk("rob_alloc", 128'(rob_alloc), 128'(ra));
      e.vmask = mask_for(data_in);
      e.d.ren = data_in;
      e.d.ps1_rdy = preg_ready(data_in.ps1);
      e.d.ps2_rdy = preg_ready(data_in.ps2);
      sb.push_back(e);
    end
    if (reset_n) begin
      if (mispredict) for (int i = 0; i < NUM_PREGS; i++) busy_m[i] = snap_m[i];
      else if (acc && data_in.opcode == 7'b1100011)
        for (int i = 0; i < NUM_PREGS; i++) snap_m[i] = busy_m[i];
      if (cdb_valid) begin busy_m[cdb_preg] = 1'b0; snap_m[cdb_preg] = 1'b0; end
      if (acc && data_in.pd_new != 0) busy_m[data_in.pd_new] = 1'b1;
      busy_m[0] = 1'b0;
    end
  endtask

  task automatic drive(input bit v, input rename_data d, input bit rr, input bit cv,
                       input logic [6:0] cp, input bit mp, input bit ar, input bit brr,
                       input bit mr);
    @(negedge clk);
    valid_in = v; data_in = d; rob_ready = rr; cdb_valid = cv; cdb_preg = cp;
    mispredict = mp; alu_ready = ar; br_ready = brr; mem_ready = mr;
    step();
  endtask

  // Monitor: checks the presented entry and retires it on fire or flush.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("idle_valids", 128'({alu_valid, br_valid, mem_valid}), 128'(3'b000));
      end else begin
        e = sb[0];
        chk("valid_route", 128'({alu_valid, br_valid, mem_valid}), 128'(e.vmask));
        chk("iq_data", 128'(iq_data), 128'(e.d));
        if (ready_for(e.vmask) || mispredict) void'(sb.pop_front());
      end
    end
  end

  initial begin
    rename_data z;
    z = '0;
    valid_in = 0; data_in = '0; rob_ready = 1; cdb_valid = 0; cdb_preg = 0;
    mispredict = 0; alu_ready = 1; br_ready = 1; mem_ready = 1;

    for (int i = 0; i < 3; i++) drive(1, mk(0, 1, 2, 3), 1, 0, 0, 0, 1, 1, 1);
    chk("reset_iq_data", 128'(iq_data), 128'(0));
    @(posedge clk); #1 reset_n = 1'b1;

    // Readiness: fresh table, dependent source, CDB bypass.
    drive(1, mk(0, 5, 0, 40), 1, 0, 0, 0, 1, 1, 1);
    drive(1, mk(0, 40, 0, 41), 1, 0, 0, 0, 1, 1, 1);
    drive(1, mk(0, 40, 41, 42), 1, 1, 40, 0, 1, 1, 1);
    drive(1, mk(0, 42, 42, 42), 1, 0, 0, 0, 1, 1, 1);
    drive(0, z, 1, 0, 0, 0, 1, 1, 1);

    // Store stalled three cycles, then fire with back-to-back accept.
    drive(1, mk(2, 3, 4, 0), 1, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, mk(0, 1, 1, 9), 1, 0, 0, 0, 1, 1, 0);
    drive(1, mk(0, 1, 1, 9), 1, 0, 0, 0, 1, 1, 1);
    drive(0, z, 1, 0, 0, 0, 1, 1, 1);

    // Branch checkpoint, younger producers, CDB clear, mispredict restore.
    drive(1, mk(1, 1, 2, 0), 1, 0, 0, 0, 1, 1, 1);
    drive(1, mk(0, 1, 2, 50), 1, 0, 0, 0, 1, 1, 1);
    drive(1, mk(3, 1, 2, 51), 1, 0, 0, 0, 1, 1, 1);
    drive(0, z, 1, 1, 51, 0, 1, 1, 0);
    drive(1, mk(0, 50, 51, 52), 1, 0, 0, 1, 1, 1, 1);
    drive(1, mk(0, 50, 51, 53), 1, 0, 0, 0, 1, 1, 1);

    // ROB full blocks accept; same-cycle set and clear of 60 keeps it busy.
    drive(1, mk(0, 1, 1, 61), 0, 0, 0, 0, 1, 1, 1);
    drive(1, mk(0, 61, 1, 60), 1, 1, 60, 0, 1, 1, 1);
    drive(1, mk(4, 60, 61, 62), 1, 0, 0, 0, 1, 1, 1);
    drive(1, mk(5, 62, 0, 0), 1, 0, 0, 0, 1, 1, 1);

    // Asynchronous reset while a branch waits in the issue register.
    drive(1, mk(0, 1, 1, 70), 1, 0, 0, 0, 1, 1, 1);
    drive(1, mk(1, 70, 2, 0), 1, 0, 0, 0, 1, 0, 1);
    drive(0, z, 1, 0, 0, 0, 1, 0, 1);
    #1;
    chk("pre_reset_br_valid", 128'(br_valid), 128'(1));
    reset_n = 1'b0;
    #1;
    chk("async_reset_valids", 128'({alu_valid, br_valid, mem_valid}), 128'(3'b000));
    chk("async_reset_iq_data", 128'(iq_data), 128'(0));
    sb.delete();
    for (int i = 0; i < NUM_PREGS; i++) begin busy_m[i] = 0; snap_m[i] = 0; end
    drive(1, mk(0, 1, 1, 3), 1, 0, 0, 0, 1, 1, 1);
    @(posedge clk); #1 reset_n = 1'b1;
    drive(1, mk(0, 70, 40, 71), 1, 0, 0, 0, 1, 1, 1);

    // Randomized traffic over a small preg window to force dependencies.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0),
            mk($urandom_range(0, 5), 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
               7'($urandom_range(0, 15))),
            ($urandom_range(0, 7) != 0), $urandom_range(0, 1), 7'($urandom_range(0, 15)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 4; i++) drive(0, z, 1, 0, 0, 0, 1, 1, 1);
    chk("drain_empty", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch.md
# dispatch

Dispatch stage between rename and the three issue queues (ALU, branch, memory). Each cycle it accepts at most one renamed instruction. It allocates the instruction's ROB entry, looks up source-operand readiness in a 128-entry physical-register busy table, and presents the instruction with ready bits to exactly one issue queue through a registered valid/ready port. It keeps one busy-table checkpoint per in-flight branch window and restores it on mispredict, in step with rename's single map/free-list checkpoint.

## Interface
- NUM_PREGS, 128, physical registers; busy-table depth.
- PREG_W, 7, physical register index width.
- TAG_W, 4, ROB tag width.

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  rename output valid.
- data_in  in  rename_data  renamed instruction (pc, ps1, ps2, pd_new, pd_old, imm, rob_tag, fu_*, ALUOp, Opcode, func3, func7).
- ready_in  out  1  dispatch can accept data_in this cycle.
- rob_alloc_valid  out  1  ROB entry write strobe (combinational, equals accept).
- rob_alloc  out  rob_alloc_data  {pc, pd_new, pd_old, rob_tag, is_branch, is_store}.
- rob_ready  in  1  ROB has a free entry.
- cdb_valid  in  1  writeback broadcast valid.
- cdb_preg  in  PREG_W  physical register written back.
- mispredict  in  1  flush from ROB.
- alu_valid / br_valid / mem_valid  out  1  issue-queue entry valid.
- alu_ready / br_ready / mem_ready  in  1  issue queue accepts.
- iq_data  out  dispatch_data  shared payload: rename fields plus ps1_rdy, ps2_rdy.

## Operation
- Accept: accept = valid_in && ready_in && !mispredict.
- ready_in = rob_ready && (!occ || fire). occ = any of alu/br/mem_valid. fire = the asserted valid ANDed with its ready.
- Routing:
  - fu_br selects br.
  - else fu_mem selects mem.
  - else alu (fu_alu, or no FU flag set).
  - Exactly one output valid at a time.
- Readiness, computed at accept:
  - psX_rdy = (psX == 0) || !busy[psX] || (cdb_valid && cdb_preg == psX).
  - The table is read before this instruction's own pd_new is marked busy, so rd==rs1 sees the old producer.
- Busy table:
  - On accept with pd_new != 0, set busy[pd_new].
  - On cdb_valid, clear busy[cdb_preg].
  - If both target the same preg in one cycle, set wins (the preg was reallocated).
  - busy[0] is hard-wired 0.
- Checkpoint:
  - On accept of a branch (Opcode 1100011), copy the busy table into snap, with the same-cycle CDB clear applied and the branch's own set excluded. Branches have no pd.
  - Every CDB clear also clears the matching snap bit.
- Mispredict:
  - Load busy from snap, then apply any same-cycle CDB clear.
  - Drop all output valids.
  - Deassert ready_in that cycle, so no ROB alloc and no accept.
- ROB allocation is issued in the accept cycle. rob_alloc fields come from data_in. is_store = Opcode 0100011.

## Timing
- Latency: accept in cycle N; the chosen *_valid is high from N+1.
- The output register holds iq_data and the valid stable until the matching ready is sampled high (no drop, no change while stalled).
- Back-to-back: fire and accept in the same cycle gives full throughput of 1 instruction/cycle.
- Ready bits are not refreshed while the instruction sits in the output register. The issue queue snoops the CDB from N+1 on.
- Reset values:
  - All *_valid = 0, ready_in = 0 while reset_n is low, rob_alloc_valid = 0.
  - iq_data = 0.
  - busy = all 0, snap = all 0.
- Reset mid-operation: the in-flight output entry is discarded. No partial ROB alloc, because alloc is combinational from accept and accept is 0 in reset.
- A mispredict that coincides with fire: the entry is considered consumed by the queue (the queue flushes itself). The valid still clears.

## Structure
- types_pkg:
  - Add dispatch_data (rename_data + ps1_rdy, ps2_rdy) and rob_alloc_data.
  - Add constants OPC_BRANCH = 7'b1100011 and OPC_STORE = 7'b0100011.
  - Add the parameter defaults.
- One sub-module, busy_table: NUM_PREGS bits plus snapshot. Ports: set_en/set_preg, clr_en/clr_preg, checkpoint, restore, two combinational read ports with CDB bypass.
- dispatch holds the routing, handshake and output register.

## Test plan
- Reset, then data_in {ps1=5, ps2=0, pd_new=40, fu_alu} with busy all 0 -> alu_valid at N+1, ps1_rdy=1, ps2_rdy=1, rob_alloc_valid=1 in N, busy[40]=1.
- Next instruction ps1=40 -> ps1_rdy=0. Repeat with cdb_valid=1, cdb_preg=40 in the accept cycle -> ps1_rdy=1.
- mem_ready=0 for 3 cycles with a store queued -> mem_valid and iq_data stable, ready_in=0. Release -> fire and next accept in the same cycle.
- Branch dispatched, then pd 50 and 51 dispatched, then CDB clears 51, then mispredict -> busy[50]=0, busy[51]=0, all valids 0, ready_in=0 that cycle.
- rob_ready=0 with valid_in=1 -> no accept, no busy change. Same-cycle set and CDB clear of preg 60 -> busy[60]=1.
- reset_n asserted low while br_valid=1 -> br_valid=0 immediately (async), busy cleared.
